// File: rtl/axis_header_inserter_if.sv
// Signal bundle for the header inserter: payload, header and egress channels.
// The slave modport is the inserter's own view; master is the upstream/downstream side.
interface axis_header_inserter_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic                    ready_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;

    logic                    valid_insert;
    logic                    ready_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD:0]    byte_insert_cnt;

    logic                    valid_out;
    logic                    ready_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    err_fmt;

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_out,
        output ready_in, ready_insert,
        output valid_out, data_out, keep_out, last_out, err_fmt
    );

    modport master (
        output valid_in, data_in, keep_in, last_in,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_out,
        input  ready_in, ready_insert,
        input  valid_out, data_out, keep_out, last_out, err_fmt
    );
endinterface

// File: rtl/axis_header_inserter.sv
// Prepends a 0..W byte header to each AXI-Stream packet, re-aligning payload beats
// through a residual register and emitting a flush beat when the tail overflows.
module axis_header_inserter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axis_header_inserter_if.slave  bus
);

    localparam int CW = BYTE_CNT_WD + 2;
    localparam logic [CW-1:0] W_C = CW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HDR    = 2'd1,
        S_STREAM = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    function automatic logic [DATA_WD-1:0] bytes_to_bits(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] r;
        r = {DATA_WD{1'b0}};
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            r[8*i +: 8] = {8{k[i]}};
        end
        return r;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] keep_low(input logic [CW-1:0] n);
        logic [DATA_BYTE_WD-1:0] r;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            r[i] = (CW'(i) < n);
        end
        return r;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] keep_top(input logic [CW-1:0] n);
        logic [DATA_BYTE_WD-1:0] r;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            r[DATA_BYTE_WD-1-i] = (CW'(i) < n);
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] count_ones(input logic [DATA_BYTE_WD-1:0] k);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            c = c + {{(CW-1){1'b0}}, k[i]};
        end
        return c;
    endfunction

    state_t                  state_q, state_d;
    logic [CW-1:0]           n_q, n_d;
    logic [DATA_WD-1:0]      r_q, r_d;
    logic [DATA_BYTE_WD-1:0] flush_keep_q, flush_keep_d;
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;
    logic                    err_q, err_d;

    logic                    load_ok_s;
    logic                    ready_in_s;
    logic                    pay_acc_s;
    logic [CW-1:0]           cnt_ext_s;
    logic [CW-1:0]           n_clamp_s;
    logic [CW-1:0]           m_s;
    logic [CW-1:0]           total_s;
    logic [2*DATA_WD-1:0]    cat_s;
    logic [DATA_WD-1:0]      shift_out_s;
    logic [DATA_WD-1:0]      flush_data_s;

    assign load_ok_s  = !valid_out_q || bus.ready_out;
    assign ready_in_s = ((state_q == S_HDR) || (state_q == S_STREAM)) && load_ok_s;
    assign pay_acc_s  = bus.valid_in && ready_in_s;
    assign cnt_ext_s  = {1'b0, bus.byte_insert_cnt};
    assign n_clamp_s  = (cnt_ext_s > W_C) ? W_C : cnt_ext_s;
    assign m_s        = bus.last_in ? count_ones(bus.keep_in) : W_C;
    assign total_s    = n_q + m_s;

    // R supplies the leading n bytes; the top W-n payload bytes fill the rest of the beat.
    assign cat_s        = {r_q, bus.data_in} >> {n_q, 3'b000};
    assign shift_out_s  = cat_s[DATA_WD-1:0];
    assign flush_data_s = (r_q << {W_C - n_q, 3'b000}) & bytes_to_bits(flush_keep_q);

    // Next-state, residual and output-register computation.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        r_d          = r_q;
        flush_keep_d = flush_keep_q;
        valid_out_d  = load_ok_s ? 1'b0 : valid_out_q;
        data_out_d   = data_out_q;
        keep_out_d   = keep_out_q;
        last_out_d   = last_out_q;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.valid_insert) begin
                    n_d     = n_clamp_s;
                    r_d     = bus.data_insert & bytes_to_bits(keep_low(n_clamp_s));
                    err_d   = (bus.keep_insert != keep_low(n_clamp_s));
                    state_d = S_HDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR, S_STREAM: begin
                if (pay_acc_s) begin
                    valid_out_d = 1'b1;
                    r_d         = bus.data_in & bytes_to_bits(keep_low(n_q));
                    err_d       = !bus.last_in && (bus.keep_in != {DATA_BYTE_WD{1'b1}});
                    if (!bus.last_in) begin
                        data_out_d = shift_out_s;
                        keep_out_d = {DATA_BYTE_WD{1'b1}};
                        last_out_d = 1'b0;
                        state_d    = S_STREAM;
                    end else if (total_s > W_C) begin
                        data_out_d   = shift_out_s;
                        keep_out_d   = {DATA_BYTE_WD{1'b1}};
                        last_out_d   = 1'b0;
                        flush_keep_d = keep_top(total_s - W_C);
                        state_d      = S_FLUSH;
                    end else begin
                        data_out_d = shift_out_s & bytes_to_bits(keep_top(total_s));
                        keep_out_d = keep_top(total_s);
                        last_out_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_FLUSH: begin
                if (load_ok_s) begin
                    valid_out_d = 1'b1;
                    data_out_d  = flush_data_s;
                    keep_out_d  = flush_keep_q;
                    last_out_d  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, residual and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            n_q          <= {CW{1'b0}};
            r_q          <= {DATA_WD{1'b0}};
            flush_keep_q <= {DATA_BYTE_WD{1'b0}};
            valid_out_q  <= 1'b0;
            data_out_q   <= {DATA_WD{1'b0}};
            keep_out_q   <= {DATA_BYTE_WD{1'b0}};
            last_out_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            r_q          <= r_d;
            flush_keep_q <= flush_keep_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            keep_out_q   <= keep_out_d;
            last_out_q   <= last_out_d;
            err_q        <= err_d;
        end
    end

    assign bus.ready_in     = ready_in_s;
    assign bus.ready_insert = (state_q == S_IDLE);
    assign bus.valid_out    = valid_out_q;
    assign bus.data_out     = data_out_q;
    assign bus.keep_out     = keep_out_q;
    assign bus.last_out     = last_out_q;
    assign bus.err_fmt      = err_q;

endmodule

// File: doc/axis_header_inserter.md
# axis_header_inserter

Parametrised AXI-Stream header inserter: prepends a per-packet header of 0..DATA_BYTE_WD bytes to a payload packet and re-aligns every payload beat across the byte shift. An extra flush beat is emitted when the shifted tail overflows. Full back-pressure, registered outputs, sustained 1 beat/cycle. Sits between the packet source and the egress AXI-Stream sink.

## Interface
- DATA_WD, 32, data width in bits, a multiple of 8
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of the byte count, which is BYTE_CNT_WD+1 bits
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in / ready_in  in / out  1 / 1  payload handshake
- data_in  in  DATA_WD  payload beat; MSB byte is first on the wire
- keep_in  in  DATA_BYTE_WD  byte enables; all ones except on the last beat, which is MSB-contiguous with 1..DATA_BYTE_WD bytes
- last_in  in  1  last payload beat
- valid_insert / ready_insert  in / out  1 / 1  header handshake, one per packet
- data_insert  in  DATA_WD  header; valid bytes are right-aligned (LSB side)
- keep_insert  in  DATA_BYTE_WD  header enables; expected value is n right-aligned ones
- byte_insert_cnt  in  BYTE_CNT_WD+1  header byte count n; 0 = pass-through; values > DATA_BYTE_WD are clamped
- valid_out / ready_out  out / in  1 / 1  output handshake
- data_out  out  DATA_WD  output beat; bytes with keep=0 are driven zero
- keep_out  out  DATA_BYTE_WD  MSB-contiguous enables
- last_out  out  1  final beat of the output packet
- err_fmt  out  1  one-cycle error pulse, see Operation

## Operation
- Byte count n: captured when the header is accepted. byte_insert_cnt is authoritative.
- Header error: err_fmt pulses for 1 cycle at header accept if keep_insert differs from n right-aligned ones.
- Payload error: err_fmt also pulses when a non-last beat is accepted with keep_in not all ones; that beat is treated as all ones.
- Residual register R holds n bytes. R is loaded with the header bytes at header accept. Per accepted payload beat:
  - output = {R, top (W−n) bytes of data_in}, where W = DATA_BYTE_WD;
  - R ← low n bytes of data_in.
- Last beat with m valid bytes:
  - if n+m ≤ W: single final beat, keep = top n+m ones, last_out=1;
  - else: full beat with last_out=0, then a flush beat of the n+m−W bytes from R, last_out=1.
- n=0: packet passes through unchanged (data, keep, last).
- n=W: the header forms a whole beat; every packet gets a flush beat.
- FSM states and transitions:
  - IDLE: ready_insert=1, ready_in=0. Header accept → HDR.
  - HDR: waiting for the first payload beat. Accept → STREAM, or → FLUSH/IDLE if that beat has last_in.
  - STREAM: beats are shifted per the rules above. Last beat → FLUSH if n+m > W, else → IDLE.
  - FLUSH: ready_in=0. Flush beat loaded → IDLE.
- Output register loads when load_ok = !valid_out || ready_out.
  - ready_in = (HDR or STREAM) && load_ok.
  - FSM enters IDLE in the cycle the last_out beat is loaded, so the next header can be accepted while that beat is still stalled.
- Reset mid-packet: all state is cleared and the partial packet is discarded; upstream must restart with a header.

## Timing
- Reset values:
  - ready_insert=1;
  - ready_in, valid_out, data_out, keep_out, last_out, err_fmt = 0;
  - FSM=IDLE, R=0.
- Latency: payload accepted at edge T → valid_out at T+1.
- Header accepted at T → earliest payload accept at T+1 → first output beat at T+2.
- Payload is never accepted in the same cycle as its header.
- Throughput: 1 beat/cycle in STREAM with ready_out=1.
- Per-packet overhead: header cycle, plus a flush cycle when needed.
- Back-pressure: while valid_out && !ready_out, data_out, keep_out and last_out hold stable and ready_in=0.
- err_fmt is registered and asserted for exactly 1 cycle, in the cycle after the offending accept.

## Test plan
- **n=1 header, 4-beat packet, ready_out=1.** Stimulus: data_insert=0x000000AA, keep_insert=0001; payload 0x12345678, 0x87654321, 0x9ABCDEF0, 0x0FEDCBA9 (last, keep 1111). Required: 0xAA123456, 0x78876543, 0x219ABCDE, 0xF00FEDCB (all keep 1111), then 0xA9000000 keep 1000 last; no err_fmt.
- **n=3, single short beat.** Stimulus: header 0x00CCDDEE keep 0111; payload 0x11223344 keep 1100 last. Required: 0xCCDDEE11 keep 1111 last=0, then 0x22000000 keep 1000 last=1.
- **n=0 pass-through.** Stimulus: same payload as test 1. Required: identical data/keep/last, each beat appearing 1 cycle after accept.
- **n=4.** Stimulus: header 0xDEADBEEF; payload 0xCAFEF00D keep 1110 last. Required: 0xDEADBEEF keep 1111, then 0xCAFEF000 keep 1110 last.
- **Back-pressure.** Stimulus: test 1 with ready_out toggling 1,0,1,0… Required: same 5-beat sequence; outputs stable during stalls; no beat lost or duplicated.
- **Errors and reset.**
  - keep_insert=0011 with byte_insert_cnt=1 → err_fmt pulses once; output uses 1 header byte.
  - rst_n low mid-packet → all outputs 0, ready_insert=1; the next packet is correct.
